// File: rtl/ni_read_rqst_queue.sv
// Read-request FIFO for the NI input unit: queues READ-flit addresses and issues them when the router can accept a response.
// Optional same-cycle bypass of an empty queue is enabled by defining NI_RRQ_BYPASS_EN.
module ni_read_rqst_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [3:0]  INFO_READ = 4'd6,
    parameter int unsigned ADDR_W    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_data_valid,
    input  logic [35:0]       in_data,
    input  logic              router_rdy,
    output logic              read_rqst_read_en,
    output logic              ni_read_rqst,
    output logic [ADDR_W-1:0] ni_read_addr
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              push;
    logic              pop;
    logic              wr_en;
    logic              empty;
    logic              full;
    logic              bypass;
    logic [ADDR_W-1:0] in_addr;
    logic              unused_in_bits;

    assign in_addr        = in_data[16 +: ADDR_W];
    assign unused_in_bits = ^{in_data[31:16+ADDR_W], in_data[15:0]};

    assign push  = in_data_valid && (in_data[35:32] == INFO_READ);
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_FULL);
    assign pop   = !empty && router_rdy;

`ifdef NI_RRQ_BYPASS_EN
    assign bypass = empty && push && router_rdy;
`else
    assign bypass = 1'b0;
`endif

    // A push into a full queue is only accepted when the head leaves in the same cycle.
    assign wr_en = push && !bypass && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (wr_en) begin
                mem_q[wr_ptr_q] <= in_addr;
            end
        end
    end

    always_comb begin
        ni_read_rqst      = !empty;
        read_rqst_read_en = pop;
        ni_read_addr      = empty ? '0 : mem_q[rd_ptr_q];
        if (bypass) begin
            ni_read_rqst      = 1'b1;
            read_rqst_read_en = 1'b1;
            ni_read_addr      = in_addr;
        end
    end

endmodule

// File: tb/tb_ni_read_rqst_queue.sv
// Scoreboard bench for ni_read_rqst_queue: stimulus queues expected addresses, a monitor checks every issued request.
// Define NI_RRQ_BYPASS_EN for both bench and RTL to exercise the bypass build.
module tb_ni_read_rqst_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inDataValid = 1'b0;
    logic [35:0] inData = '0;
    logic        routerRdy = 1'b0;
    logic        readEn;
    logic        rqst;
    logic [5:0]  addr;

    int          checkCount = 0;
    int          passCount = 0;
    logic [5:0]  expQ [$];
    bit          monEn = 1'b0;

    always #5 clk = ~clk;

    ni_read_rqst_queue dut (
        .clk               (clk),
        .rst               (rst),
        .in_data_valid     (inDataValid),
        .in_data           (inData),
        .router_rdy        (routerRdy),
        .read_rqst_read_en (readEn),
        .ni_read_rqst      (rqst),
        .ni_read_addr      (addr)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Upper address bits and payload are filled with junk the queue must ignore.
    task automatic applyStimulus(input bit valid, input logic [3:0] info, input logic [5:0] a,
                                 input bit rdy, input bit expectPush);
        inDataValid = valid;
        inData      = {info, 10'h2AA, a, 16'hA5C3};
        routerRdy   = rdy;
        if (expectPush) begin
            expQ.push_back(a);
        end
        @(posedge clk);
        #1;
        inDataValid = 1'b0;
    endtask

    task automatic idleCycles(input int n, input bit rdy);
        inDataValid = 1'b0;
        routerRdy   = rdy;
        repeat (n) @(posedge clk);
        #1;
        routerRdy = 1'b0;
    endtask

    task automatic checkOutputs(input string tag, input int eRqst, input int eAddr, input int eEn);
        #2;
        checkOutput({tag, ".rqst"}, rqst, eRqst);
        checkOutput({tag, ".addr"}, addr, eAddr);
        checkOutput({tag, ".readEn"}, readEn, eEn);
    endtask

    task automatic checkEmpty(input string tag);
        #2;
        checkOutput({tag, ".pending"}, expQ.size(), 0);
        checkOutput({tag, ".rqst"}, rqst, 0);
        checkOutput({tag, ".addr"}, addr, 0);
        checkOutput({tag, ".readEn"}, readEn, 0);
    endtask

    // Monitor: every issued request must match the oldest expected address.
    always @(negedge clk) begin
        if (monEn && readEn) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedPop", readEn, 0);
            end else begin
                checkOutput("popAddr", addr, expQ.pop_front());
                checkOutput("popRqst", rqst, 1);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b1;
        monEn = 1'b1;
        checkOutputs("reset", 0, 0, 0);

        // Single push: visible one cycle later, not issued while router busy.
        applyStimulus(1'b1, 4'd6, 6'd5, 1'b0, 1'b1);
        checkOutputs("t1", 1, 5, 0);
        idleCycles(1, 1'b1);
        checkEmpty("t1");

        // Back-to-back pushes drained at full rate.
        applyStimulus(1'b1, 4'd6, 6'd3, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'd6, 6'd9, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'd6, 6'd17, 1'b0, 1'b1);
        idleCycles(3, 1'b1);
        checkEmpty("t2");

        // Overflow push is dropped.
        applyStimulus(1'b1, 4'd6, 6'd1, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'd6, 6'd2, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'd6, 6'd4, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'd6, 6'd8, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'd6, 6'd40, 1'b0, 1'b0);
        checkOutputs("t3Full", 1, 1, 0);
        idleCycles(6, 1'b1);
        checkEmpty("t3");

        // Push and pop together while full; a following push must still be dropped.
        applyStimulus(1'b1, 4'd6, 6'd11, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'd6, 6'd22, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'd6, 6'd33, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'd6, 6'd44, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'd6, 6'd7, 1'b1, 1'b1);
        applyStimulus(1'b1, 4'd6, 6'd50, 1'b0, 1'b0);
        checkOutputs("t4", 1, 22, 0);
        idleCycles(6, 1'b1);
        checkEmpty("t4");

        // Non-READ flits and invalid flits are ignored.
        applyStimulus(1'b1, 4'd6, 6'd21, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'd5, 6'd13, 1'b0, 1'b0);
        checkOutputs("t5Info", 1, 21, 0);
        applyStimulus(1'b0, 4'd6, 6'd14, 1'b0, 1'b0);
        checkOutputs("t5Valid", 1, 21, 0);
        idleCycles(3, 1'b1);
        checkEmpty("t5");

        // Reset mid-operation discards pending entries.
        applyStimulus(1'b1, 4'd6, 6'd25, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'd6, 6'd26, 1'b0, 1'b1);
        checkOutputs("t6Pre", 1, 25, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        expQ.delete();
        checkOutputs("t6Rst", 0, 0, 0);
        idleCycles(3, 1'b1);
        checkEmpty("t6Flush");

        // Empty queue, push with router ready.
        @(posedge clk);
        #1;
        inDataValid = 1'b1;
        inData      = {4'd6, 10'h155, 6'd12, 16'h0F0F};
        routerRdy   = 1'b1;
        expQ.push_back(6'd12);
`ifdef NI_RRQ_BYPASS_EN
        checkOutputs("t6Bypass", 1, 12, 1);
        @(posedge clk);
        #1;
        inDataValid = 1'b0;
`else
        checkOutputs("t6NoBypass", 0, 0, 0);
        @(posedge clk);
        #1;
        inDataValid = 1'b0;
        checkOutputs("t6Next", 1, 12, 1);
        idleCycles(1, 1'b1);
`endif
        checkEmpty("t6End");

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
